// File: rtl/mcu_router_pkg.sv
// Shared types and constants for the MCU frame router: FSM states,
// well-known target IDs and the drop-counter ceiling.
package mcu_router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    FWD     = 2'd2,
    DISCARD = 2'd3
  } router_state_e;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;
  localparam logic [7:0] TGT_SDC = 8'd3;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/mcu_frame_router.sv
// Routes MCU SPI frames to per-function targets by their leading ID byte,
// muxes the selected reply back, and merges target interrupts.
module mcu_frame_router
  import mcu_router_pkg::*;
#(
  parameter int NUM_TARGETS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_strobe,
  input  logic                     rx_start,
  input  logic [7:0]               rx_data,
  output logic [7:0]               tx_data,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_data,
  input  logic [8*NUM_TARGETS-1:0] tgt_dout,
  input  logic [NUM_TARGETS-1:0]   tgt_int,
  output logic                     int_out_n,
  output logic [7:0]               drop_cnt
);

  localparam int         SEL_W  = $clog2(NUM_TARGETS);
  localparam logic [7:0] NUM_T8 = 8'(NUM_TARGETS);

  router_state_e          state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   fwd_en, fwd_first, drop_inc;
  logic [NUM_TARGETS-1:0] sel_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // A start byte always wins, so a new frame aborts whatever was in flight.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    fwd_en    = 1'b0;
    fwd_first = 1'b0;
    drop_inc  = 1'b0;
    if (rx_strobe) begin
      if (rx_start) begin
        if (rx_data < NUM_T8) begin
          sel_d   = rx_data[SEL_W-1:0];
          state_d = CMD;
        end else begin
          state_d  = DISCARD;
          drop_inc = 1'b1;
        end
      end else begin
        case (state_q)
          CMD: begin
            fwd_en    = 1'b1;
            fwd_first = 1'b1;
            state_d   = FWD;
          end
          FWD:     fwd_en = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
  end

  // Registered byte stream towards the targets: one cycle behind rx.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_strobe <= '0;
      tgt_start  <= 1'b0;
      tgt_data   <= 8'h00;
      drop_cnt   <= 8'h00;
    end else begin
      tgt_strobe <= fwd_en ? sel_onehot : '0;
      if (fwd_en) begin
        tgt_start <= fwd_first;
        tgt_data  <= rx_data;
      end
      if (drop_inc && drop_cnt != DROP_CNT_MAX)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // While the command byte is clocked in, the MCU reads the pending-IRQ mask.
  always_comb begin
    case (state_q)
      CMD:     tx_data = 8'(tgt_int);
      FWD:     tx_data = tgt_dout[{sel_q, 3'b000} +: 8];
      default: tx_data = 8'h00;
    endcase
  end

  assign int_out_n = ~|tgt_int;

endmodule

// File: tb/tb_mcu_frame_router.sv
// Directed bench for mcu_frame_router with hand-computed expectations.
module tb_mcu_frame_router;
  import mcu_router_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_strobe, rx_start;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [3:0]  tgt_strobe;
  logic        tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_dout;
  logic [3:0]  tgt_int;
  logic        int_out_n;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  mcu_frame_router #(.NUM_TARGETS(4)) dut (
    .clk(clk), .reset(reset), .rx_strobe(rx_strobe), .rx_start(rx_start),
    .rx_data(rx_data), .tx_data(tx_data), .tgt_strobe(tgt_strobe),
    .tgt_start(tgt_start), .tgt_data(tgt_data), .tgt_dout(tgt_dout),
    .tgt_int(tgt_int), .int_out_n(int_out_n), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of rx input, return 1 time unit after the capturing edge.
  task automatic send(input logic s, input logic st, input logic [7:0] d);
    @(negedge clk);
    rx_strobe = s;
    rx_start  = st;
    rx_data   = d;
    @(posedge clk);
    #1;
    rx_strobe = 1'b0;
    rx_start  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rx_strobe = 1'b0;
    rx_start  = 1'b0;
    rx_data   = 8'h00;
    tgt_int   = 4'b0000;
    tgt_dout  = {8'h3D, 8'h7E, 8'h11, 8'h5C};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobe", tgt_strobe, 4'b0000);
    chk("rst_start", tgt_start, 1'b0);
    chk("rst_data", tgt_data, 8'h00);
    chk("rst_drop", drop_cnt, 8'h00);
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_int_n", int_out_n, 1'b1);
    reset = 1'b0;

    // Frame to SYS target
    send(1, 1, TGT_SYS);
    chk("f1_id_strobe", tgt_strobe, 4'b0000);
    chk("f1_cmd_tx", tx_data, 8'h00);
    send(1, 0, 8'h00);
    chk("f1_b0_strobe", tgt_strobe, 4'b0001);
    chk("f1_b0_start", tgt_start, 1'b1);
    chk("f1_b0_data", tgt_data, 8'h00);
    chk("f1_fwd_tx", tx_data, 8'h5C);
    send(0, 0, 8'hEE);
    chk("f1_gap_strobe", tgt_strobe, 4'b0000);
    chk("f1_gap_start_hold", tgt_start, 1'b1);
    send(1, 0, 8'hAA);
    chk("f1_b1_strobe", tgt_strobe, 4'b0001);
    chk("f1_b1_start", tgt_start, 1'b0);
    chk("f1_b1_data", tgt_data, 8'hAA);
    send(1, 0, 8'hBB);
    chk("f1_b2_strobe", tgt_strobe, 4'b0001);
    chk("f1_b2_data", tgt_data, 8'hBB);
    chk("f1_b2_tx", tx_data, 8'h5C);

    // Back-to-back frame to OSD target
    send(1, 1, TGT_OSD);
    send(1, 0, 8'h04);
    chk("f2_b0_strobe", tgt_strobe, 4'b0100);
    chk("f2_b0_start", tgt_start, 1'b1);
    chk("f2_b0_data", tgt_data, 8'h04);
    chk("f2_tx", tx_data, 8'h7E);
    send(1, 0, 8'h53);
    chk("f2_b1_strobe", tgt_strobe, 4'b0100);
    chk("f2_b1_start", tgt_start, 1'b0);
    chk("f2_b1_data", tgt_data, 8'h53);
    send(0, 0, 8'h00);
    chk("f2_idle_strobe", tgt_strobe, 4'b0000);

    // Interrupt aggregation and CMD-state IRQ mask readback
    tgt_int = 4'b1010;
    send(1, 1, TGT_HID);
    chk("irq_int_n", int_out_n, 1'b0);
    chk("irq_cmd_tx", tx_data, 8'h0A);
    tgt_int = 4'b0000;
    #1;
    chk("irq_clear_int_n", int_out_n, 1'b1);
    chk("irq_clear_tx", tx_data, 8'h00);

    // Invalid target ID
    send(1, 1, 8'h07);
    chk("bad_drop1", drop_cnt, 8'h01);
    chk("bad_tx", tx_data, 8'h00);
    send(1, 0, 8'h11);
    chk("bad_b0_strobe", tgt_strobe, 4'b0000);
    send(1, 0, 8'h22);
    chk("bad_b1_strobe", tgt_strobe, 4'b0000);
    chk("bad_drop_still1", drop_cnt, 8'h01);
    for (int i = 0; i < 299; i++) begin
      send(1, 1, 8'h07);
      send(1, 0, 8'h11);
    end
    chk("bad_drop_sat", drop_cnt, 8'hFF);
    send(1, 1, 8'h80);
    chk("bad_drop_hold", drop_cnt, 8'hFF);

    // Abort mid-frame with a new start
    send(1, 1, TGT_HID);
    send(1, 0, 8'h03);
    chk("ab_b0_strobe", tgt_strobe, 4'b0010);
    send(1, 0, 8'h44);
    chk("ab_b1_data", tgt_data, 8'h44);
    send(1, 1, TGT_SDC);
    chk("ab_start_strobe", tgt_strobe, 4'b0000);
    chk("ab_start_data_hold", tgt_data, 8'h44);
    send(1, 0, 8'h05);
    chk("ab_new_strobe", tgt_strobe, 4'b1000);
    chk("ab_new_start", tgt_start, 1'b1);
    chk("ab_new_data", tgt_data, 8'h05);
    chk("ab_new_tx", tx_data, 8'h3D);
    chk("ab_drop_unchanged", drop_cnt, 8'hFF);

    // Reset mid-FWD, with a strobe in the reset cycle
    send(1, 0, 8'h66);
    chk("rm_pre_data", tgt_data, 8'h66);
    @(negedge clk);
    reset     = 1'b1;
    rx_strobe = 1'b1;
    rx_start  = 1'b0;
    rx_data   = 8'h77;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rx_strobe = 1'b0;
    chk("rm_strobe", tgt_strobe, 4'b0000);
    chk("rm_start", tgt_start, 1'b0);
    chk("rm_data", tgt_data, 8'h00);
    chk("rm_drop", drop_cnt, 8'h00);
    chk("rm_tx", tx_data, 8'h00);
    send(1, 0, 8'h88);
    chk("rm_after_strobe", tgt_strobe, 4'b0000);
    chk("rm_after_data", tgt_data, 8'h00);

    // ID-only frame followed by a new start: nothing forwarded or counted
    send(1, 1, TGT_SYS);
    send(1, 1, TGT_HID);
    chk("id_only_strobe", tgt_strobe, 4'b0000);
    send(1, 0, 8'h09);
    chk("id_only_next_strobe", tgt_strobe, 4'b0010);
    chk("id_only_next_start", tgt_start, 1'b1);
    chk("id_only_next_data", tgt_data, 8'h09);
    chk("id_only_drop", drop_cnt, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_frame_router.md
Name: mcu_frame_router

Overview:
- Sits between the MCU SPI byte receiver and the per-function MCU targets: system control, HID, OSD and SD card.
- Each MCU frame starts with a target-ID byte. The router strips that byte, forwards the rest of the frame as a per-target byte stream (strobe/start/data), and muxes the selected target's reply byte back to the SPI transmitter.
- Also aggregates per-target interrupt requests into the single MCU interrupt line and counts frames dropped for an invalid target ID.

Parameters:
- NUM_TARGETS, 4, number of attached targets (legal 2..8). Derived localparam SEL_W = clog2(NUM_TARGETS).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_strobe  in  1  one-cycle pulse: rx_data holds a received byte
- rx_start  in  1  qualifies rx_strobe: byte is the first of a frame
- rx_data  in  8  received byte
- tx_data  out  8  reply byte to SPI transmitter (combinational)
- tgt_strobe  out  NUM_TARGETS  one-hot byte strobe per target (registered)
- tgt_start  out  1  shared; qualifies tgt_strobe as the command (first) byte
- tgt_data  out  8  shared forwarded byte (registered)
- tgt_dout  in  8*NUM_TARGETS  reply byte of each target; target i occupies bits [8i+7:8i]
- tgt_int  in  NUM_TARGETS  per-target interrupt request (level)
- int_out_n  out  1  active-low MCU interrupt; low while any tgt_int bit is 1
- drop_cnt  out  8  saturating count of frames dropped for an invalid target ID

Behaviour:
- Byte acceptance: a byte is accepted in any cycle with rx_strobe=1. rx_start is ignored when rx_strobe=0. Strobes on consecutive cycles are supported.
- States:
  - IDLE: no frame.
  - CMD: target selected, waiting for the command byte.
  - FWD: forwarding payload bytes.
  - DISCARD: invalid target; bytes swallowed until the next frame.
- Start byte (rx_strobe & rx_start): accepted in every state and aborts any frame in progress.
  - If rx_data < NUM_TARGETS: sel <= rx_data[SEL_W-1:0], state <= CMD.
  - Otherwise: state <= DISCARD, and drop_cnt increments, saturating at 8'hFF.
  - A start byte is never forwarded to any target.
- CMD, on a non-start byte:
  - tgt_strobe[sel]=1, tgt_start=1, tgt_data=rx_data on the next cycle.
  - state <= FWD.
- FWD, on each non-start byte: tgt_strobe[sel]=1, tgt_start=0, tgt_data=rx_data on the next cycle. There is no length limit.
- IDLE or DISCARD, on a non-start byte: the byte is ignored. No strobe is issued and drop_cnt does not change.
- Latency: exactly 1 cycle from rx_strobe to tgt_strobe.
  - tgt_strobe is high for exactly one cycle and is all-zero otherwise.
  - tgt_start and tgt_data hold their last values between strobes.
- tx_data (combinational):
  - CMD: zero-extended tgt_int mask, so the MCU reads pending interrupt sources while it sends the command byte.
  - FWD: tgt_dout slice of sel.
  - IDLE, DISCARD: 8'h00.
- Target reply timing: a target updates its data_out on its strobe. The MCU samples tx_data during the following byte, so the router adds no reply buffering.
- int_out_n = ~|tgt_int, purely combinational and independent of frame state. Acknowledge is the target's own business: it is carried in-band inside that target's frames.
- Reset values: state=IDLE, sel=0, tgt_strobe=0, tgt_start=0, tgt_data=8'h00, drop_cnt=8'h00. tx_data is therefore 8'h00.
- Reset mid-frame: the router returns to IDLE, and the remaining non-start bytes of the aborted frame are ignored. A strobe is not issued in the reset cycle even if rx_strobe=1.
- Frame of only an ID byte followed by a new start: the router leaves CMD for the new frame. Nothing is forwarded and nothing is counted.

Decomposition:
- Package mcu_router_pkg holds:
  - the state enum (IDLE, CMD, FWD, DISCARD);
  - target ID constants TGT_SYS=0, TGT_HID=1, TGT_OSD=2, TGT_SDC=3;
  - DROP_CNT_MAX=8'hFF.
- Single module with no sub-module. The reply mux and saturating counter are trivial in-line logic.

Test Plan:
- After reset, frame {start 8'h00, 8'h00, 8'hAA, 8'hBB} with tgt_dout[7:0]=8'h5C:
  - tgt_strobe=4'b0001 on 3 cycles, each 1 cycle after the matching rx_strobe;
  - first forwarded byte has tgt_start=1 and data 8'h00, then 8'hAA and 8'hBB with tgt_start=0;
  - tx_data=8'h5C while in FWD.
- Frame {start 8'h02, 8'h04, 8'h53} sent on consecutive cycles:
  - only tgt_strobe[2] pulses, twice, back-to-back;
  - tgt_strobe[0], [1] and [3] stay 0.
- tgt_int=4'b1010 with frame {start 8'h01}: int_out_n=0, and tx_data=8'h0A while in CMD. When tgt_int is cleared to 0, int_out_n=1 on the same cycle.
- Invalid ID: frame {start 8'h07, 8'h11, 8'h22} gives no tgt_strobe and drop_cnt=1. After 300 such frames drop_cnt=8'hFF and holds.
- Abort: frame {start 8'h01, 8'h03, 8'h44} then a new start 8'h03 mid-frame, then 8'h05. The next forwarded byte is on tgt_strobe[3] with tgt_start=1 and data 8'h05.
- Reset mid-FWD: assert reset for 1 cycle between payload bytes. All outputs return to reset values, and the following non-start byte produces no strobe.
